mem_load_queue: RTL

//  Parametrised memory-stage response tracker. Allows up to DEPTH outstanding data-cache requests
//  (loads and stores) between EX issue and WB. Captures in-order data_ok responses, performs
//  lb/lbu/lh/lhu/lw/lwl/lwr extraction and merge, and presents retired results to WB in program order.

---
 rtl/mem_load_queue.sv | 119 +++++++++++
 1 files changed

// File: rtl/mem_load_queue.sv
// mem_load_queue: in-order tracker of outstanding data-cache requests with load extraction and WB retire
module mem_load_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_load,
    input  logic [6:0]        req_type,
    input  logic [1:0]        req_offset,
    input  logic [31:0]       req_rt,
    input  logic [4:0]        req_dest,
    input  logic [31:0]       req_pc,
    input  logic              data_ok,
    input  logic [DATA_W-1:0] rdata,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_result,
    output logic              out_gr_we,
    output logic [4:0]        out_dest,
    output logic [31:0]       out_pc,
    output logic              busy,
    output logic              orphan_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr, rsp_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic [DEPTH-1:0] e_valid, e_done, e_dead;
    logic             e_load   [DEPTH];
    logic [6:0]       e_type   [DEPTH];
    logic [1:0]       e_off    [DEPTH];
    logic [31:0]      e_rt     [DEPTH];
    logic [4:0]       e_dest   [DEPTH];
    logic [31:0]      e_pc     [DEPTH];
    logic [31:0]      e_result [DEPTH];

    logic        push, rsp_hit, pop;
    logic [31:0] rd, rt, rsp_result;
    logic [6:0]  ty;
    logic [4:0]  sh;
    logic [7:0]  bv;
    logic [15:0] hv;

    assign req_ready  = count < CW'(DEPTH);
    assign busy       = count != '0;
    assign push       = req_valid & req_ready;
    assign rsp_hit    = data_ok & e_valid[rsp_ptr] & ~e_done[rsp_ptr];
    assign out_valid  = e_valid[rd_ptr] & e_done[rd_ptr] & ~e_dead[rd_ptr] & ~flush;
    assign pop        = (out_valid & out_ready) | (e_valid[rd_ptr] & e_done[rd_ptr] & e_dead[rd_ptr]);
    assign out_result = e_result[rd_ptr];
    assign out_gr_we  = e_load[rd_ptr];
    assign out_dest   = e_dest[rd_ptr];
    assign out_pc     = e_pc[rd_ptr];

    always_comb begin
        rd = 32'(rdata);
        rt = e_rt[rsp_ptr];
        ty = e_type[rsp_ptr];
        sh = {e_off[rsp_ptr], 3'b000};
        bv = 8'(rd >> sh);
        hv = e_off[rsp_ptr][1] ? rd[31:16] : rd[15:0];
        rsp_result = !e_load[rsp_ptr] ? '0 :
                     ty[6] ? {{24{bv[7]}}, bv} :
                     ty[5] ? {24'b0, bv} :
                     ty[4] ? {{16{hv[15]}}, hv} :
                     ty[3] ? {16'b0, hv} :
                     ty[2] ? rd :
                     ty[1] ? (rd << (5'd24 - sh)) | (rt & (32'h00FF_FFFF >> sh)) :
                     ty[0] ? (rd >> sh) | (rt & ~(32'hFFFF_FFFF >> sh)) : '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rsp_ptr    <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            e_valid    <= '0;
            e_done     <= '0;
            e_dead     <= '0;
            orphan_err <= 1'b0;
        end else begin
            count <= count + CW'(push) - CW'(pop);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (rsp_hit) rsp_ptr <= rsp_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (data_ok && !rsp_hit) orphan_err <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                if (flush && e_valid[i]) e_dead[i] <= 1'b1;
                if (push && wr_ptr == AW'(i)) begin
                    e_valid[i] <= 1'b1;
                    e_done[i]  <= 1'b0;
                    e_dead[i]  <= flush;
                end
                if (rsp_hit && rsp_ptr == AW'(i)) e_done[i] <= 1'b1;
                if (pop && rd_ptr == AW'(i)) e_valid[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push && wr_ptr == AW'(i)) begin
                e_load[i] <= req_is_load;
                e_type[i] <= req_type;
                e_off[i]  <= req_offset;
                e_rt[i]   <= req_rt;
                e_dest[i] <= req_dest;
                e_pc[i]   <= req_pc;
            end
            if (rsp_hit && rsp_ptr == AW'(i)) e_result[i] <= rsp_result;
        end
    end
endmodule
